// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux channel by channel, samples Y after each dwell,
// and hands the packed 4-bit frame downstream over valid/ready.
module mux_scan_sampler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       y_in,
  output logic       S0,
  output logic       S1,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       overrun
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    buf_q, buf_d;
  logic [3:0]    frame_q, frame_d;
  logic          fv_q, fv_d;
  logic          ovr_q, ovr_d;

  logic done;
  logic hs;
  logic load;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ch_d    = 2'd0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (ch_q != 2'd3) begin
            buf_d[ch_q] = y_in;
            ch_d        = ch_q + 2'd1;
          end else begin
            done    = 1'b1;
            ch_d    = 2'd0;
            state_d = continuous ? SCAN : IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // A finished frame may only replace one that is gone or leaving now.
    hs      = fv_q & frame_ready;
    load    = done & (~fv_q | hs);
    frame_d = frame_q;
    fv_d    = fv_q;
    if (load) begin
      frame_d = {y_in, buf_q};
      fv_d    = 1'b1;
    end else if (hs) begin
      fv_d    = 1'b0;
    end
    if (done && !load) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      cnt_q   <= '0;
      buf_q   <= 3'd0;
      frame_q <= 4'd0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign S0          = ch_q[0];
  assign S1          = ch_q[1];
  assign busy        = (state_q == SCAN);
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: directed scenarios plus random traffic
// against a position-in-scan reference model; a DWELL=1 copy alongside.
module tb_mux_scan_sampler;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, rdy;
  logic [3:0] in_v;
  logic       y, s0, s1, busy, fv, ovr;
  logic [3:0] frame;

  logic       r1, st1;
  logic [3:0] in1;
  logic       y1, a1, b1, busy1, fv1, ovr1;
  logic [3:0] frame1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y  = in_v[{s1, s0}];
  assign y1 = in1[{b1, a1}];

  mux_scan_sampler #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(cont),
    .y_in(y), .S0(s0), .S1(s1), .busy(busy), .frame(frame),
    .frame_valid(fv), .frame_ready(rdy), .overrun(ovr)
  );

  mux_scan_sampler #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(r1), .start(st1), .continuous(1'b0),
    .y_in(y1), .S0(a1), .S1(b1), .busy(busy1), .frame(frame1),
    .frame_valid(fv1), .frame_ready(1'b1), .overrun(ovr1)
  );

  // Model: a scan is a run of 4*DW cycles; position decides the channel.
  bit         m_busy;
  int         m_pos;
  logic [3:0] m_smp;
  logic [3:0] m_frame;
  bit         m_fv;
  bit         m_ovr;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    bit r, st, co, rd, done, hs;
    logic [3:0] iv;
    int k;
    r = rst_n; st = start; co = cont; rd = rdy; iv = in_v;
    @(posedge clk);
    done = 0;
    if (!r) begin
      m_busy = 0; m_pos = 0; m_smp = '0;
      m_frame = '0; m_fv = 0; m_ovr = 0;
    end else begin
      hs = m_fv && rd;
      if (!m_busy) begin
        if (st) begin
          m_busy = 1; m_pos = 0; m_ovr = 0;
        end
      end else begin
        k = m_pos / DW;
        if (m_pos % DW == DW - 1) m_smp[k] = iv[k];
        m_pos++;
        if (m_pos == 4 * DW) begin
          done = 1; m_pos = 0; m_busy = co;
        end
      end
      if (done && (!m_fv || hs)) begin
        m_frame = m_smp; m_fv = 1;
      end else begin
        if (done) m_ovr = 1;
        if (hs) m_fv = 0;
      end
    end
    #1;
    chk("sel", {2'b00, s1, s0}, m_busy ? 4'(m_pos / DW) : 4'd0);
    chk("busy", {3'b000, busy}, {3'b000, m_busy});
    chk("fvalid", {3'b000, fv}, {3'b000, m_fv});
    chk("frame", frame, m_frame);
    chk("overrun", {3'b000, ovr}, {3'b000, m_ovr});
  endtask

  initial begin
    rst_n = 0; start = 0; cont = 0; rdy = 1; in_v = 4'b1101;
    r1 = 0; st1 = 0; in1 = 4'b0110;
    m_busy = 0; m_pos = 0; m_smp = '0;
    m_frame = '0; m_fv = 0; m_ovr = 0;

    // DWELL=1 copy: one channel per cycle
    tick();
    chk("d1_rst_sel", {2'b00, b1, a1}, 4'd0);
    chk("d1_rst_fv", {3'b000, fv1}, 4'd0);
    chk("d1_rst_frame", frame1, 4'd0);
    r1 = 1; st1 = 1;
    tick();
    st1 = 0;
    chk("d1_busy", {3'b000, busy1}, 4'd1);
    chk("d1_sel0", {2'b00, b1, a1}, 4'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("d1_sel", {2'b00, b1, a1}, 4'(k));
      chk("d1_fv_lo", {3'b000, fv1}, 4'd0);
    end
    tick();
    chk("d1_fv", {3'b000, fv1}, 4'd1);
    chk("d1_frame", frame1, 4'b0110);
    chk("d1_idle", {2'b00, busy1, b1 | a1}, 4'd0);
    chk("d1_ovr", {3'b000, ovr1}, 4'd0);
    tick();
    chk("d1_fv_clr", {3'b000, fv1}, 4'd0);

    rst_n = 1;
    tick();

    // single shot, consumer ready
    start = 1; tick(); start = 0;
    repeat (20) tick();

    // single shot, consumer stalled
    rdy = 0; start = 1; tick(); start = 0;
    repeat (40) tick();
    chk("t2_frame", frame, 4'b1101);
    rdy = 1;
    repeat (2) tick();

    // continuous, stalled: second frame dropped
    cont = 1; rdy = 0; start = 1; tick(); start = 0;
    repeat (33) tick();
    chk("t3_ovr_set", {3'b000, ovr}, 4'd1);
    rdy = 1; cont = 0;
    repeat (20) tick();
    start = 1; tick(); start = 0;
    chk("t3_ovr_clr", {3'b000, ovr}, 4'd0);
    repeat (18) tick();

    // continuous, ready, inputs change between frames
    cont = 1; rdy = 1; in_v = 4'b1101;
    start = 1; tick(); start = 0;
    repeat (16) tick();
    chk("t4_frame_a", frame, 4'b1101);
    in_v = 4'b0010;
    repeat (16) tick();
    chk("t4_frame_b", frame, 4'b0010);
    chk("t4_fv", {3'b000, fv}, 4'd1);
    cont = 0;
    repeat (20) tick();

    // reset in channel 2 dwell
    in_v = 4'b1101;
    start = 1; tick(); start = 0;
    repeat (10) tick();
    rst_n = 0; tick();
    chk("t5_sel", {2'b00, s1, s0}, 4'd0);
    chk("t5_state", {2'b00, busy, fv}, 4'd0);
    chk("t5_frame", frame, 4'd0);
    rst_n = 1; in_v = 4'b0101;
    start = 1; tick(); start = 0;
    repeat (18) tick();
    chk("t5_fresh", frame, 4'b0101);

    // random traffic
    repeat (400) begin
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      rdy   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) in_v = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
